// File: rtl/ifu_fetch.sv
// ifu_fetch: single-issue instruction fetch unit feeding the decoder.
// Owns the architectural PC. Each cycle of operation it issues one request on the
// instruction-memory port, captures the returned word, hands it to the decoder and
// waits for the resolved next PC before fetching again. A decoded EBREAK (halt)
// or a misaligned next PC stops fetching until reset.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   imem_req_valid/ready/addr    fetch request (addr = pc)
//   imem_resp_valid/data         one-cycle response pulse per accepted request
//   inst_valid/ready, inst, pc   instruction handed to the decoder
//   npc_valid, npc               resolved next PC from execute/write-back
//   halt                         decoded EBREAK of current inst
//   halted, fault                sticky stop indications
//   inst_cnt                     instructions handed to the decoder (wraps)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  input  logic        halt,
  output logic        halted,
  output logic        fault,
  output logic [31:0] inst_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_REQ       = 3'd0,
    S_WAIT_RESP = 3'd1,
    S_VALID     = 3'd2,
    S_WAIT_NPC  = 3'd3,
    S_HALTED    = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   r_inst;
  logic [XLEN-1:0]   w_inst_nxt;
  logic [XLEN-1:0]   r_inst_cnt;
  logic [XLEN-1:0]   w_inst_cnt_nxt;
  logic              r_req_valid;
  logic              r_inst_valid;
  logic              r_halted;
  logic              r_fault;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_inst_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_inst_cnt <= w_inst_cnt_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_nxt     = r_inst;
    w_inst_cnt_nxt = r_inst_cnt;
    unique case (r_state)
      S_REQ: begin
        // r_req_valid is low for the first cycle out of reset, so gate acceptance on it
        if (r_req_valid && imem_req_ready) begin
          w_state_nxt = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (imem_resp_valid) begin
          w_inst_nxt  = imem_resp_data;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (r_inst_valid && inst_ready) begin
          w_inst_cnt_nxt = r_inst_cnt + XLEN'(1);
          w_state_nxt    = S_WAIT_NPC;
        end
      end
      S_WAIT_NPC: begin
        // halt wins over a simultaneous next PC
        if (halt) begin
          w_state_nxt = S_HALTED;
        end else if (npc_valid) begin
          if (npc[1:0] != 2'b00) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_pc_nxt    = npc;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      S_FAULT:  w_state_nxt = S_FAULT;
      default:  w_state_nxt = S_REQ;
    endcase
  end

  // Registered handshake/status outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_req_valid  <= (w_state_nxt == S_REQ);
      r_inst_valid <= (w_state_nxt == S_VALID);
      r_halted     <= (w_state_nxt == S_HALTED);
      r_fault      <= (w_state_nxt == S_FAULT);
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign pc             = r_pc;
  assign halted         = r_halted;
  assign fault          = r_fault;
  assign inst_cnt       = r_inst_cnt;

endmodule
